// File: rtl/ulpb_tx_sequencer.sv
// ULPB transmit sequencer: buffers whole host messages and replays them word by
// word over the node's 4-phase TX handshake, reporting one status per message.
module ulpb_tx_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_last,
    input  logic                  host_priority,
    output logic                  status_valid,
    output logic                  status_succ,
    output logic                  status_ovf,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_REQ,
    output logic                  TX_PEND,
    output logic                  PRIORITY,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  prio;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_REL, S_RESP, S_RACK, S_FLUSH
    } state_t;

    entry_t          mem_q [DEPTH];
    entry_t          head, wr_entry;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     msg_cnt_q, msg_cnt_d, fifo_cnt;
    logic            full, push, pop, ovf_clr;

    logic [1:0]      ack_sync_q, succ_sync_q, fail_sync_q;
    logic            ack_s, succ_s, fail_s;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_q, req_d, pend_q, pend_d, prio_q, prio_d;
    logic                  rack_q, rack_d, result_q, result_d;
    logic                  flush_q, flush_d, last_q, last_d;
    logic                  sv_q, sv_d, ss_q, ss_d, so_q, so_d;

    // Node-side handshake lines are asynchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_sync_q  <= '0;
            succ_sync_q <= '0;
            fail_sync_q <= '0;
        end else begin
            ack_sync_q  <= {ack_sync_q[0], TX_ACK};
            succ_sync_q <= {succ_sync_q[0], TX_SUCC};
            fail_sync_q <= {fail_sync_q[0], TX_FAIL};
        end
    end

    assign ack_s  = ack_sync_q[1];
    assign succ_s = succ_sync_q[1];
    assign fail_s = fail_sync_q[1];

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign full       = (fifo_cnt == (AW+1)'(DEPTH));
    assign host_ready = ~full;
    assign push       = host_valid & ~full & ~ovf_clr;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_entry   = '{addr: host_addr, data: host_data, last: host_last, prio: host_priority};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    always_comb begin
        wr_ptr_d  = ovf_clr ? '0 : wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = ovf_clr ? '0 : rd_ptr_q + (AW+1)'(pop);
        msg_cnt_d = msg_cnt_q;
        case ({push & host_last, pop & head.last})
            2'b10:   msg_cnt_d = msg_cnt_q + (AW+1)'(1);
            2'b01:   msg_cnt_d = msg_cnt_q - (AW+1)'(1);
            default: msg_cnt_d = msg_cnt_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        req_d    = req_q;
        pend_d   = pend_q;
        prio_d   = prio_q;
        rack_d   = rack_q;
        result_d = result_q;
        flush_d  = flush_q;
        last_d   = last_q;
        sv_d     = 1'b0;
        ss_d     = 1'b0;
        so_d     = 1'b0;
        pop      = 1'b0;
        ovf_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                prio_d = 1'b0;
                // A full FIFO with no complete message can never drain: drop it.
                if (full && msg_cnt_q == '0) begin
                    ovf_clr = 1'b1;
                    sv_d    = 1'b1;
                    so_d    = 1'b1;
                end else if (msg_cnt_q != '0) begin
                    addr_d  = head.addr;
                    prio_d  = head.prio;
                    data_d  = head.data;
                    pend_d  = ~head.last;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fail_s) begin
                    req_d    = 1'b0;
                    rack_d   = 1'b1;
                    result_d = 1'b0;
                    flush_d  = 1'b1;
                    state_d  = S_RACK;
                end else if (ack_s) begin
                    pop     = 1'b1;
                    last_d  = head.last;
                    req_d   = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (fail_s) begin
                    rack_d   = 1'b1;
                    result_d = 1'b0;
                    // Nothing left to discard once the final word has gone out.
                    flush_d  = ~last_q;
                    state_d  = S_RACK;
                end else if (!ack_s) begin
                    if (last_q) begin
                        state_d = S_RESP;
                    end else begin
                        data_d  = head.data;
                        pend_d  = ~head.last;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_RESP: begin
                if (succ_s || fail_s) begin
                    rack_d   = 1'b1;
                    result_d = succ_s;
                    flush_d  = 1'b0;
                    state_d  = S_RACK;
                end
            end
            S_RACK: begin
                if (!succ_s && !fail_s) begin
                    rack_d = 1'b0;
                    if (flush_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        sv_d    = 1'b1;
                        ss_d    = result_q;
                        prio_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                pop = (fifo_cnt != '0);
                if (fifo_cnt == '0 || head.last) begin
                    sv_d    = 1'b1;
                    prio_d  = 1'b0;
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            msg_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            pend_q    <= 1'b0;
            prio_q    <= 1'b0;
            rack_q    <= 1'b0;
            result_q  <= 1'b0;
            flush_q   <= 1'b0;
            last_q    <= 1'b0;
            sv_q      <= 1'b0;
            ss_q      <= 1'b0;
            so_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            msg_cnt_q <= msg_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            prio_q    <= prio_d;
            rack_q    <= rack_d;
            result_q  <= result_d;
            flush_q   <= flush_d;
            last_q    <= last_d;
            sv_q      <= sv_d;
            ss_q      <= ss_d;
            so_q      <= so_d;
        end
    end

    assign TX_ADDR      = addr_q;
    assign TX_DATA      = data_q;
    assign TX_REQ       = req_q;
    assign TX_PEND      = pend_q;
    assign PRIORITY     = prio_q;
    assign TX_RESP_ACK  = rack_q;
    assign status_valid = sv_q;
    assign status_succ  = ss_q;
    assign status_ovf   = so_q;
endmodule

// File: tb/tb_ulpb_tx_sequencer.sv
// Directed bench for ulpb_tx_sequencer: a hand-driven node model on the TX port
// and fixed host messages with hand-computed expectations.
module tb_ulpb_tx_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        host_valid, host_ready, host_last, host_priority;
    logic [7:0]  host_addr;
    logic [31:0] host_data;
    logic        status_valid, status_succ, status_ovf;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_REQ, TX_PEND, PRIORITY, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ulpb_tx_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .host_last(host_last), .host_priority(host_priority),
        .status_valid(status_valid), .status_succ(status_succ), .status_ovf(status_ovf),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
        .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // sel: 0 TX_REQ, 1 TX_RESP_ACK, 2 status_valid; returns negedges waited.
    task automatic wait_for(input int sel, input logic val, input string tag, output int cyc);
        logic s;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            case (sel)
                0:       s = TX_REQ;
                1:       s = TX_RESP_ACK;
                default: s = status_valid;
            endcase
        end while (s !== val && cyc < 60);
        if (s !== val) begin
            checks++;
            $error("FAIL %s_timeout: observed %b expected %b", tag, s, val);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d, input logic l, input logic p);
        host_valid = 1'b1; host_addr = a; host_data = d; host_last = l; host_priority = p;
        @(negedge clk);
        host_valid = 1'b0; host_last = 1'b0; host_priority = 1'b0;
    endtask

    task automatic node_word(input logic [31:0] d, input logic pend, input logic prio,
                             input logic [7:0] a, input string tag, output int rise_lat);
        int c;
        wait_for(0, 1'b1, tag, rise_lat);
        chkv({tag, "_data"}, 64'(TX_DATA), 64'(d));
        chkv({tag, "_addr"}, 64'(TX_ADDR), 64'(a));
        chk1({tag, "_pend"}, TX_PEND, pend);
        chk1({tag, "_prio"}, PRIORITY, prio);
        TX_ACK = 1'b1;
        wait_for(0, 1'b0, tag, c);
        chkv({tag, "_ack_to_req_fall"}, 64'(c), 64'd3);
        TX_ACK = 1'b0;
    endtask

    task automatic resp(input logic succ, input string tag);
        int c;
        repeat (4) @(negedge clk);
        if (succ) TX_SUCC = 1'b1; else TX_FAIL = 1'b1;
        wait_for(1, 1'b1, tag, c);
        chkv({tag, "_rack_rise_lat"}, 64'(c), 64'd3);
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        wait_for(1, 1'b0, tag, c);
        chkv({tag, "_rack_fall_lat"}, 64'(c), 64'd3);
        chk1({tag, "_status_valid"}, status_valid, 1'b1);
        chk1({tag, "_status_succ"}, status_succ, succ);
        chk1({tag, "_status_ovf"}, status_ovf, 1'b0);
        @(negedge clk);
        chk1({tag, "_status_pulse_end"}, status_valid, 1'b0);
    endtask

    initial begin
        int  c;
        logic saw;
        resetn = 1'b0;
        host_valid = 1'b0; host_addr = '0; host_data = '0; host_last = 1'b0; host_priority = 1'b0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_host_ready", host_ready, 1'b1);
        chk1("rst_tx_req", TX_REQ, 1'b0);
        chk1("rst_rack", TX_RESP_ACK, 1'b0);
        chk1("rst_status", status_valid, 1'b0);
        chk1("rst_prio", PRIORITY, 1'b0);
        chk1("rst_pend", TX_PEND, 1'b0);
        chkv("rst_data", 64'(TX_DATA), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single word message
        push(8'hB0, 32'hDEADBEEF, 1'b1, 1'b0);
        chk1("t1_req_not_yet", TX_REQ, 1'b0);
        @(negedge clk);
        chk1("t1_req_rise", TX_REQ, 1'b1);
        node_word(32'hDEADBEEF, 1'b0, 1'b0, 8'hB0, "t1", c);
        resp(1'b1, "t1");
        chkv("t1_fifo_empty", 64'(dut.fifo_cnt), 64'd0);
        chkv("t1_msg_cnt", 64'(dut.msg_cnt_q), 64'd0);

        // Three words, priority; later words' addr/priority must be ignored
        push(8'hA5, 32'h11111111, 1'b0, 1'b1);
        push(8'h00, 32'h22222222, 1'b0, 1'b0);
        push(8'h01, 32'h33333333, 1'b1, 1'b0);
        node_word(32'h11111111, 1'b1, 1'b1, 8'hA5, "t2w1", c);
        node_word(32'h22222222, 1'b1, 1'b1, 8'hA5, "t2w2", c);
        chkv("t2_ack_fall_to_req", 64'(c), 64'd3);
        node_word(32'h33333333, 1'b0, 1'b1, 8'hA5, "t2w3", c);
        chkv("t2_ack_fall_to_req3", 64'(c), 64'd3);
        resp(1'b1, "t2");
        chk1("t2_prio_idle", PRIORITY, 1'b0);

        // Failure on word 2 of 4, then a queued message
        push(8'h33, 32'hA1, 1'b0, 1'b0);
        push(8'h33, 32'hA2, 1'b0, 1'b0);
        push(8'h33, 32'hA3, 1'b0, 1'b0);
        push(8'h33, 32'hA4, 1'b1, 1'b0);
        push(8'h44, 32'hB5, 1'b1, 1'b0);
        node_word(32'hA1, 1'b1, 1'b0, 8'h33, "t3w1", c);
        wait_for(0, 1'b1, "t3w2", c);
        chkv("t3w2_data", 64'(TX_DATA), 64'hA2);
        TX_FAIL = 1'b1;
        wait_for(0, 1'b0, "t3_req_drop", c);
        chkv("t3_fail_to_req_drop", 64'(c), 64'd3);
        chk1("t3_rack_rise", TX_RESP_ACK, 1'b1);
        TX_FAIL = 1'b0;
        wait_for(1, 1'b0, "t3_rack_fall", c);
        chkv("t3_rack_fall_lat", 64'(c), 64'd3);
        chk1("t3_no_status_yet", status_valid, 1'b0);
        wait_for(2, 1'b1, "t3_flush_status", c);
        chkv("t3_flush_cycles", 64'(c), 64'd3);
        chk1("t3_status_succ", status_succ, 1'b0);
        chk1("t3_status_ovf", status_ovf, 1'b0);
        node_word(32'hB5, 1'b0, 1'b0, 8'h44, "t3b", c);
        resp(1'b1, "t3b");
        chkv("t3_msg_cnt", 64'(dut.msg_cnt_q), 64'd0);

        // Oversized message overflows the FIFO
        for (int i = 0; i < 8; i++) push(8'h10, 32'(i), 1'b0, 1'b0);
        chk1("t4_full_not_ready", host_ready, 1'b0);
        chk1("t4_no_status_yet", status_valid, 1'b0);
        @(negedge clk);
        chk1("t4_status_valid", status_valid, 1'b1);
        chk1("t4_status_ovf", status_ovf, 1'b1);
        chk1("t4_status_succ", status_succ, 1'b0);
        chk1("t4_ready_again", host_ready, 1'b1);
        chkv("t4_fifo_cleared", 64'(dut.fifo_cnt), 64'd0);
        @(negedge clk);
        chk1("t4_status_end", status_valid, 1'b0);
        chk1("t4_ovf_low", status_ovf, 1'b0);
        chk1("t4_req_idle", TX_REQ, 1'b0);

        // Push-last coincides with pop-last
        push(8'h50, 32'hC1, 1'b1, 1'b0);
        push(8'h55, 32'hC2, 1'b0, 1'b0);
        wait_for(0, 1'b1, "t5w1", c);
        chkv("t5w1_data", 64'(TX_DATA), 64'hC1);
        chk1("t5w1_pend", TX_PEND, 1'b0);
        TX_ACK = 1'b1;
        @(negedge clk);
        @(negedge clk);
        host_valid = 1'b1; host_addr = 8'h00; host_data = 32'hC3; host_last = 1'b1;
        @(negedge clk);
        host_valid = 1'b0; host_last = 1'b0;
        chk1("t5_popped", TX_REQ, 1'b0);
        chkv("t5_msg_cnt_held", 64'(dut.msg_cnt_q), 64'd1);
        TX_ACK = 1'b0;
        resp(1'b1, "t5a");
        chk1("t5_next_req_no_gap", TX_REQ, 1'b1);
        node_word(32'hC2, 1'b1, 1'b0, 8'h55, "t5w2", c);
        node_word(32'hC3, 1'b0, 1'b0, 8'h55, "t5w3", c);
        resp(1'b1, "t5b");

        // Reset while a request is outstanding
        push(8'h66, 32'h66, 1'b1, 1'b0);
        wait_for(0, 1'b1, "t6_req", c);
        #1 resetn = 1'b0;
        #1;
        chk1("t6_req_async_drop", TX_REQ, 1'b0);
        chk1("t6_rack_low", TX_RESP_ACK, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (status_valid) saw = 1'b1;
        end
        chk1("t6_no_status", saw, 1'b0);
        chk1("t6_host_ready", host_ready, 1'b1);
        chkv("t6_msg_cnt", 64'(dut.msg_cnt_q), 64'd0);
        chk1("t6_req_stays_low", TX_REQ, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
